// File: rtl/dac_spi_serdes_pkg.sv
// Shared types and helpers for the DAC/ADC SPI frame engine.
package dac_spi_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} spi_state_t;

    // Bits needed to hold n-1, never less than one.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dac_spi_serdes_if.sv
// Parallel word handshake between the sample-control FSM and the SPI engine.
interface dac_spi_serdes_if #(
    parameter int unsigned WIDTH = 12
);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             busy;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, busy
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/dac_spi_serdes_clk_tick.sv
// CLK_DIV down-counter: one-cycle tick every CLK_DIV running cycles, reloaded by clear.
module spi_clk_tick
    import dac_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);
    localparam int unsigned     CW   = clog2_min1(CLK_DIV);
    localparam logic [CW-1:0]   LOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = LOAD;
        end else if (run) begin
            if (cnt_q == '0) begin
                tick  = 1'b1;
                cnt_d = LOAD;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/dac_spi_serdes.sv
// Full-duplex SPI mode-0 frame engine; generates sclk/cs_n and returns the captured word.
// Optional build macro LSB_FIRST_EN: shift LSB first in both directions.
module dac_spi_serdes
    import dac_spi_pkg::*;
#(
    parameter int unsigned WIDTH   = 12,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic            clk,
    input  logic            reset,
    dac_spi_serdes_if.slave bus,
    input  logic            sdi,
    output logic            sclk,
    output logic            sdo,
    output logic            cs_n
);
    localparam int unsigned   BW       = clog2_min1(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    spi_state_t       state_q, state_d;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             sclk_q, sclk_d;
    logic             cs_n_q, cs_n_d;
    logic             accept, run, tick;

    assign run    = (state_q != IDLE);
    assign accept = bus.tx_valid && (state_q == IDLE);

    spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .run   (run),
        .tick  (tick)
    );

    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        bit_cnt_d  = bit_cnt_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    tx_shift_d = bus.tx_data;
                    bit_cnt_d  = LAST_BIT;
                    sclk_d     = 1'b0;
                    cs_n_d     = 1'b0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (tick) state_d = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
`ifdef LSB_FIRST_EN
                        rx_shift_d = {sdi, rx_shift_q[WIDTH-1:1]};
`else
                        rx_shift_d = {rx_shift_q[WIDTH-2:0], sdi};
`endif
                    end else if (bit_cnt_q != '0) begin
`ifdef LSB_FIRST_EN
                        tx_shift_d = {1'b0, tx_shift_q[WIDTH-1:1]};
`else
                        tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
`endif
                        bit_cnt_d  = bit_cnt_q - 1'b1;
                    end else begin
                        // Last falling edge: sdo keeps the final bit through HOLD.
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_n_d     = 1'b1;
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            bit_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            bit_cnt_q  <= bit_cnt_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
        end
    end

`ifdef LSB_FIRST_EN
    assign sdo = tx_shift_q[0];
`else
    assign sdo = tx_shift_q[WIDTH-1];
`endif
    assign sclk         = sclk_q;
    assign cs_n         = cs_n_q;
    assign bus.tx_ready = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
endmodule

// File: tb/tb_dac_spi_serdes.sv
// Scoreboard bench for dac_spi_serdes; build with LSB_FIRST_EN for the 16-bit LSB-first variant.
module tb_dac_spi_serdes;
`ifdef LSB_FIRST_EN
    localparam int unsigned W = 16;
    localparam int unsigned D = 1;
`else
    localparam int unsigned W = 12;
    localparam int unsigned D = 2;
`endif
    localparam int unsigned FRAME = (2 * W + 2) * D;
    localparam int unsigned LAT   = FRAME + 1;
    localparam int unsigned PER   = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sdi, sclk, sdo, cs_n;
    logic loop = 1'b1;
    logic sdi_val = 1'b0;

    always #5 clk = ~clk;
    assign sdi = loop ? sdo : sdi_val;

    dac_spi_serdes_if #(.WIDTH(W)) bus();

    dac_spi_serdes #(.WIDTH(W), .CLK_DIV(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .sdi   (sdi),
        .sclk  (sclk),
        .sdo   (sdo),
        .cs_n  (cs_n)
    );

    typedef struct {
        logic [W-1:0] data;
        longint       acc;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Pin-level monitor: frame lengths, sclk edges and sdo bits seen on rising sclk.
    logic         prev_cs = 1'b1, prev_sclk = 1'b0, prev_rv = 1'b0;
    int unsigned  cs_low_len = 0, last_cs_low = 0, cs_high_len = 1000, last_cs_high = 0;
    int unsigned  rises = 0, last_rises = 0, frames = 0, rv_pulses = 0;
    logic [W-1:0] sdo_word = '0, last_sdo_word = '0;
    logic         sclk_bad = 1'b0, rv_long = 1'b0;

    always @(negedge clk) begin
        if (cs_n === 1'b0) begin
            if (prev_cs) begin
                frames++;
                last_cs_high = cs_high_len;
                cs_low_len   = 0;
                rises        = 0;
            end
            cs_low_len++;
            if (sclk === 1'b1 && !prev_sclk) begin
                rises++;
                sdo_word = {sdo_word[W-2:0], sdo};
            end
        end else begin
            if (!prev_cs) begin
                last_cs_low   = cs_low_len;
                last_rises    = rises;
                last_sdo_word = sdo_word;
                cs_high_len   = 0;
            end
            cs_high_len++;
            if (sclk === 1'b1) sclk_bad = 1'b1;
        end
        if (bus.rx_valid === 1'b1) begin
            rv_pulses++;
            if (prev_rv) rv_long = 1'b1;
        end
        prev_cs   = (cs_n !== 1'b0);
        prev_sclk = (sclk === 1'b1);
        prev_rv   = (bus.rx_valid === 1'b1);
    end

    function automatic logic [W-1:0] model(input logic [W-1:0] d);
        return loop ? d : {W{sdi_val}};
    endfunction

    function automatic logic [W-1:0] wire_order(input logic [W-1:0] d);
        logic [W-1:0] r;
`ifdef LSB_FIRST_EN
        for (int i = 0; i < W; i++) r[i] = d[W-1-i];
`else
        r = d;
`endif
        return r;
    endfunction

    task automatic tick_n(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a word, wait (bounded) for acceptance, log the expected reply.
    task automatic send(input logic [W-1:0] d, input logic hold_valid);
        int unsigned k = 0;
        exp_t e;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        while (bus.tx_ready !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (bus.tx_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: tx_ready=%b required 1", bus.tx_ready);
        end else begin
            e.data = model(d);
            e.acc  = $time;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!hold_valid) bus.tx_valid = 1'b0;
    endtask

    // Wait (bounded) for rx_valid, then pop and compare data, latency and pulse width.
    task automatic wait_rx(input string name);
        int unsigned k = 0;
        exp_t e, nx;
        @(negedge clk);
        while (bus.rx_valid !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (bus.rx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_rx_timeout: rx_valid=%b required 1", name, bus.rx_valid);
            return;
        end
        if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
            nx.data = model(bus.tx_data);
            nx.acc  = $time;
            exp_q.push_back(nx);
        end
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_unexpected_rx: rx_data=%h with empty scoreboard", name, bus.rx_data);
        end else begin
            e = exp_q.pop_front();
            if (bus.rx_data !== e.data) begin
                n_fail++;
                $display("FAIL %s_rx_data: got %h required %h", name, bus.rx_data, e.data);
            end
            n_checks++;
            if (($time - e.acc) / PER != LAT) begin
                n_fail++;
                $display("FAIL %s_latency: got %0d required %0d", name, ($time - e.acc) / PER, LAT);
            end
        end
        @(negedge clk);
        n_checks++;
        if (bus.rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_rx_pulse: rx_valid=%b required 0 one cycle later", name, bus.rx_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick_n(3);
        @(negedge clk);
        n_checks += 7;
        if (cs_n !== 1'b1)          begin n_fail++; $display("FAIL reset_cs_n: got %b required 1", cs_n); end
        if (sclk !== 1'b0)          begin n_fail++; $display("FAIL reset_sclk: got %b required 0", sclk); end
        if (sdo !== 1'b0)           begin n_fail++; $display("FAIL reset_sdo: got %b required 0", sdo); end
        if (bus.rx_data !== '0)     begin n_fail++; $display("FAIL reset_rx_data: got %h required 0", bus.rx_data); end
        if (bus.rx_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_rx_valid: got %b required 0", bus.rx_valid); end
        if (bus.tx_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_tx_ready: got %b required 1", bus.tx_ready); end
        if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick_n(2);
    endtask

    task automatic test_loopback(input logic [W-1:0] d);
        loop = 1'b1;
        send(d, 1'b0);
        wait_rx("loopback");
        n_checks += 3;
        if (last_cs_low != FRAME) begin
            n_fail++; $display("FAIL loopback_cs_low: got %0d required %0d", last_cs_low, FRAME);
        end
        if (last_rises != W) begin
            n_fail++; $display("FAIL loopback_sclk_rises: got %0d required %0d", last_rises, W);
        end
        if (last_sdo_word !== wire_order(d)) begin
            n_fail++; $display("FAIL loopback_sdo_bits: got %h required %h", last_sdo_word, wire_order(d));
        end
        tick_n(3);
    endtask

    task automatic test_sdi_ones();
        loop    = 1'b0;
        sdi_val = 1'b1;
        send('0, 1'b0);
        wait_rx("sdi_ones");
        n_checks += 2;
        if (last_rises != W) begin
            n_fail++; $display("FAIL sdi_ones_sclk_rises: got %0d required %0d", last_rises, W);
        end
        if (last_cs_low != FRAME) begin
            n_fail++; $display("FAIL sdi_ones_cs_low: got %0d required %0d", last_cs_low, FRAME);
        end
        loop    = 1'b1;
        sdi_val = 1'b0;
        tick_n(3);
    endtask

    task automatic test_back_to_back();
        int unsigned f0 = frames;
        loop = 1'b1;
        send(W'(12'h123), 1'b1);
        bus.tx_data = W'(12'h456);
        wait_rx("b2b_first");
        bus.tx_valid = 1'b0;
        wait_rx("b2b_second");
        n_checks += 2;
        if (last_cs_high != 1) begin
            n_fail++; $display("FAIL b2b_cs_high_gap: got %0d required 1", last_cs_high);
        end
        if (frames != f0 + 2) begin
            n_fail++; $display("FAIL b2b_frames: got %0d required %0d", frames - f0, 2);
        end
        tick_n(3);
    endtask

    task automatic test_reset_mid_frame();
        int unsigned rv0;
        loop = 1'b1;
        send(W'(12'hABC), 1'b0);
        tick_n(19);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks += 4;
        if (cs_n !== 1'b1)         begin n_fail++; $display("FAIL abort_cs_n: got %b required 1", cs_n); end
        if (sclk !== 1'b0)         begin n_fail++; $display("FAIL abort_sclk: got %b required 0", sclk); end
        if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL abort_tx_ready: got %b required 1", bus.tx_ready); end
        if (bus.rx_data !== '0)    begin n_fail++; $display("FAIL abort_rx_data: got %h required 0", bus.rx_data); end
        exp_q.delete();
        rv0 = rv_pulses;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick_n(FRAME + 20);
        n_checks += 2;
        if (rv_pulses != rv0)   begin n_fail++; $display("FAIL abort_no_rx_valid: got %0d pulses required 0", rv_pulses - rv0); end
        if (bus.rx_data !== '0) begin n_fail++; $display("FAIL abort_rx_data_after: got %h required 0", bus.rx_data); end
    endtask

    task automatic test_busy_ignored();
        int unsigned f0 = frames;
        loop = 1'b1;
        send(W'(12'h3C5), 1'b0);
        tick_n(5);
        bus.tx_data  = '1;
        bus.tx_valid = 1'b1;
        tick_n(1);
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        wait_rx("busy");
        tick_n(FRAME + 10);
        n_checks += 2;
        if (frames != f0 + 1) begin
            n_fail++; $display("FAIL busy_frames: got %0d required 1", frames - f0);
        end
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL busy_scoreboard: %0d entries left required 0", exp_q.size());
        end
    endtask

    initial begin
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        test_reset();
`ifdef LSB_FIRST_EN
        test_loopback(16'h8001);
`else
        test_loopback(12'hA5C);
`endif
        test_sdi_ones();
        test_back_to_back();
        test_reset_mid_frame();
        test_busy_ignored();
        n_checks += 2;
        if (sclk_bad) begin n_fail++; $display("FAIL sclk_idle: sclk seen high with cs_n high"); end
        if (rv_long)  begin n_fail++; $display("FAIL rx_valid_width: rx_valid high two cycles running"); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
